// File: rtl/ledstrip_pkg.sv
`default_nettype none
// ============================================================================
// Package : ledstrip_pkg
// Brief   : Shared widths, channel offsets, command record and scaling helper.
// Rev     : 1.0
// ============================================================================
package ledstrip_pkg;

    localparam int PIXEL_W  = 24;
    localparam int REPEAT_W = 8;
    localparam int CMD_W    = PIXEL_W + REPEAT_W + 1;

    localparam int R_OFS = 16;
    localparam int G_OFS = 8;
    localparam int B_OFS = 0;

    typedef struct packed {
        logic [PIXEL_W-1:0]  rgb;
        logic [REPEAT_W-1:0] repeat_cnt;
        logic                latch;
    } cmd_t;

    // (c * (b + 1)) >> 8; bit 16 of the product can never be set.
    function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] b);
        logic [8:0]  b1;
        logic [16:0] prod;
        b1   = {1'b0, b} + 9'd1;
        prod = {9'd0, c} * {8'd0, b1};
        return prod[15:8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ledstrip_pixel_feeder_if.sv
`default_nettype none
// ============================================================================
// Interface : ledstrip_pixel_feeder_if
// Brief     : Command write handshake and pixel output handshake of the feeder.
// Rev       : 1.0
// ============================================================================
interface ledstrip_pixel_feeder_if;
    import ledstrip_pkg::*;

    logic                wr_valid;
    logic                wr_ready;
    logic [PIXEL_W-1:0]  wr_rgb;
    logic [REPEAT_W-1:0] wr_repeat;
    logic                wr_latch;

    logic                out_valid;
    logic                out_ready;
    logic [PIXEL_W-1:0]  out_data;
    logic                out_latch;

    modport slave (
        input  wr_valid, wr_rgb, wr_repeat, wr_latch, out_ready,
        output wr_ready, out_valid, out_data, out_latch
    );

    modport master (
        output wr_valid, wr_rgb, wr_repeat, wr_latch, out_ready,
        input  wr_ready, out_valid, out_data, out_latch
    );
endinterface
`default_nettype wire

// File: rtl/ledstrip_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module : ledstrip_cmd_fifo
// Brief  : Synchronous FIFO with registered full flag, level count and flush.
// Rev    : 1.0
// ============================================================================
module ledstrip_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  wire                         clk,
    input  wire                         reset,
    input  wire                         flush,
    input  wire                         wr_en,
    input  wire  [WIDTH-1:0]            wr_data,
    input  wire                         rd_en,
    output logic [WIDTH-1:0]            rd_data,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH+1)-1:0]  level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_full;
    logic             w_push;
    logic             w_pop;
    logic [LVL_W-1:0] w_level_nxt;

    // A write coincident with flush is dropped.
    assign w_push      = wr_en & ~r_full & ~flush;
    assign w_pop       = rd_en & (r_level != '0) & ~flush;
    assign w_level_nxt = r_level + LVL_W'(w_push) - LVL_W'(w_pop);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LVL_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= wr_data;
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign full    = r_full;
    assign empty   = (r_level == '0);
    assign level   = r_level;
endmodule
`default_nettype wire

// File: rtl/ledstrip_pixel_feeder.sv
`default_nettype none
// ============================================================================
// Module : ledstrip_pixel_feeder
// Brief  : Buffers pixel commands, expands repeats, scales and reorders pixels.
// Rev    : 1.0
// ============================================================================
module ledstrip_pixel_feeder
    import ledstrip_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter bit GRB_ORDER = 1'b1
) (
    input  wire                          clk,
    input  wire                          reset,
    ledstrip_pixel_feeder_if.slave       bus,
    input  wire  [7:0]                   brightness,
    input  wire                          flush,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);
    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_SEND  = 1'b1;

    logic [0:0]          r_state;
    logic [REPEAT_W-1:0] r_remaining;
    logic                r_cur_latch;
    logic                r_active;
    logic                r_out_valid;
    logic [PIXEL_W-1:0]  r_out_data;
    logic                r_out_latch;

    logic [CMD_W-1:0]    w_fifo_rdata;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_pop;
    logic                w_xfer;
    cmd_t                w_head;
    logic [7:0]          w_r;
    logic [7:0]          w_g;
    logic [7:0]          w_b;
    logic [PIXEL_W-1:0]  w_ordered;

    assign w_pop  = (r_state == S_EMPTY) & ~w_fifo_empty & ~flush;
    assign w_xfer = r_out_valid & bus.out_ready;

    ledstrip_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .wr_en   (bus.wr_valid),
        .wr_data ({bus.wr_rgb, bus.wr_repeat, bus.wr_latch}),
        .rd_en   (w_pop),
        .rd_data (w_fifo_rdata),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty),
        .level   (fifo_level)
    );

    // Brightness is applied at load time, so later changes leave the slot alone.
    assign w_head = cmd_t'(w_fifo_rdata);
    assign w_r    = scale_chan(w_head.rgb[R_OFS +: 8], brightness);
    assign w_g    = scale_chan(w_head.rgb[G_OFS +: 8], brightness);
    assign w_b    = scale_chan(w_head.rgb[B_OFS +: 8], brightness);

    generate
        if (GRB_ORDER) begin : g_grb
            assign w_ordered = {w_g, w_r, w_b};
        end else begin : g_rgb
            assign w_ordered = {w_r, w_g, w_b};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_EMPTY;
            r_remaining <= '0;
            r_cur_latch <= 1'b0;
            r_active    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_latch <= 1'b0;
        end else if (flush) begin
            r_state     <= S_EMPTY;
            r_remaining <= '0;
            r_cur_latch <= 1'b0;
            r_active    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_latch <= 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_pop) begin
                        r_remaining <= w_head.repeat_cnt;
                        r_cur_latch <= w_head.latch;
                        r_active    <= 1'b1;
                        r_out_data  <= w_ordered;
                        r_out_latch <= w_head.latch & (w_head.repeat_cnt == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_xfer) begin
                        if (r_remaining == '0) begin
                            r_state     <= S_EMPTY;
                            r_active    <= 1'b0;
                            r_out_valid <= 1'b0;
                            r_out_latch <= 1'b0;
                        end else begin
                            r_remaining <= r_remaining - 1'b1;
                            r_out_latch <= r_cur_latch & (r_remaining == 8'd1);
                        end
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    assign bus.wr_ready  = ~w_fifo_full;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_latch = r_out_latch;
    assign busy          = r_active | (fifo_level != '0);
endmodule
`default_nettype wire

// File: tb/tb_ledstrip_pixel_feeder.sv
`default_nettype none
// ============================================================================
// Module : tb_ledstrip_pixel_feeder
// Brief  : Directed self-checking bench for ledstrip_pixel_feeder (GRB and RGB builds).
// Rev    : 1.0
// ============================================================================
module tb_ledstrip_pixel_feeder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] brightness;
    logic       flush;
    logic       busy;
    logic [2:0] fifo_level;
    logic       busy2;
    logic [2:0] fifo_level2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] cap_data  [$];
    logic        cap_latch [$];

    ledstrip_pixel_feeder_if bus ();
    ledstrip_pixel_feeder_if bus2 ();

    always #5 clk = ~clk;

    ledstrip_pixel_feeder #(.DEPTH(4), .GRB_ORDER(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .brightness (brightness),
        .flush      (flush),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    ledstrip_pixel_feeder #(.DEPTH(4), .GRB_ORDER(1'b0)) dut_rgb (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus2.slave),
        .brightness (brightness),
        .flush      (flush),
        .busy       (busy2),
        .fifo_level (fifo_level2)
    );

    function automatic logic [23:0] grb(input logic [23:0] rgb);
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

    // All driving and sampling happens 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic write_cmd(input logic [23:0] rgb, input logic [7:0] rep, input logic lat);
        bus.wr_rgb    = rgb;
        bus.wr_repeat = rep;
        bus.wr_latch  = lat;
        bus.wr_valid  = 1'b1;
        tick();
        bus.wr_valid  = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        bit done = 0;
        for (int c = 0; c < max_cycles && !done; c++) begin
            if (bus.out_valid && bus.out_ready) begin
                cap_data.push_back(bus.out_data);
                cap_latch.push_back(bus.out_latch);
            end
            if (!busy && !bus.out_valid)
                done = 1;
            else
                tick();
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL drain_timeout busy=%0b out_valid=%0b required idle within %0d cycles",
                     busy, bus.out_valid, max_cycles);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({bus.wr_ready, bus.out_valid, bus.out_data, bus.out_latch, busy, fifo_level} !==
            {1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL reset_state wr_ready=%0b out_valid=%0b out_data=%h out_latch=%0b busy=%0b level=%0d",
                     bus.wr_ready, bus.out_valid, bus.out_data, bus.out_latch, busy, fifo_level);
        end
    endtask

    task automatic test_single();
        do_reset();
        brightness    = 8'd255;
        bus.out_ready = 1'b1;
        write_cmd(24'h112233, 8'd0, 1'b1);
        n_checks++;
        if (bus.out_valid !== 1'b0 || fifo_level !== 3'd1) begin
            n_fail++;
            $display("FAIL single_no_bypass out_valid=%0b level=%0d required 0/1", bus.out_valid, fifo_level);
        end
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 24'h221133 || bus.out_latch !== 1'b1) begin
            n_fail++;
            $display("FAIL single_pixel valid=%0b data=%h latch=%0b required 1/221133/1",
                     bus.out_valid, bus.out_data, bus.out_latch);
        end
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done out_valid=%0b busy=%0b required 0/0", bus.out_valid, busy);
        end
    endtask

    task automatic test_repeat();
        do_reset();
        brightness    = 8'd255;
        bus.out_ready = 1'b1;
        cap_data.delete();
        cap_latch.delete();
        write_cmd(24'h112233, 8'd2, 1'b1);
        drain(20);
        n_checks++;
        if (cap_data.size() != 3) begin
            n_fail++;
            $display("FAIL repeat_count got=%0d required=3", cap_data.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (cap_data[i] !== 24'h221133 || cap_latch[i] !== (i == 2)) begin
                    n_fail++;
                    $display("FAIL repeat_pixel%0d data=%h latch=%0b required 221133/%0b",
                             i, cap_data[i], cap_latch[i], (i == 2));
                end
            end
        end
    endtask

    task automatic test_brightness();
        do_reset();
        brightness    = 8'd127;
        bus.out_ready = 1'b0;
        write_cmd(24'hFF8000, 8'd1, 1'b0);
        tick();
        brightness = 8'd0;
        tick();
        n_checks++;
        if (bus.out_data !== 24'h407F00) begin
            n_fail++;
            $display("FAIL brightness_127 got=%h required=407f00", bus.out_data);
        end
        bus.out_ready = 1'b1;
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 24'h407F00) begin
            n_fail++;
            $display("FAIL brightness_midcmd valid=%0b data=%h required 1/407f00", bus.out_valid, bus.out_data);
        end
        tick();
        write_cmd(24'hFF8000, 8'd0, 1'b0);
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 24'h000000) begin
            n_fail++;
            $display("FAIL brightness_zero valid=%0b data=%h required 1/000000", bus.out_valid, bus.out_data);
        end
    endtask

    task automatic test_back_to_back();
        int          accepted = 0;
        logic [23:0] rgb [6];
        bit          stable = 1;
        do_reset();
        brightness    = 8'd255;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++)
            rgb[i] = {8'(i * 16 + 1), 8'(i * 16 + 2), 8'(i * 16 + 3)};
        for (int i = 0; i < 6; i++) begin
            bus.wr_rgb    = rgb[i];
            bus.wr_repeat = 8'd0;
            bus.wr_latch  = 1'b0;
            bus.wr_valid  = 1'b1;
            if (bus.wr_ready)
                accepted++;
            tick();
        end
        bus.wr_valid = 1'b0;
        n_checks++;
        if (accepted != 5 || bus.wr_ready !== 1'b0 || fifo_level !== 3'd4) begin
            n_fail++;
            $display("FAIL b2b_fill accepted=%0d wr_ready=%0b level=%0d required 5/0/4",
                     accepted, bus.wr_ready, fifo_level);
        end
        for (int c = 0; c < 10; c++) begin
            if (bus.out_valid !== 1'b1 || bus.out_data !== grb(rgb[0]))
                stable = 0;
            tick();
        end
        n_checks++;
        if (!stable) begin
            n_fail++;
            $display("FAIL b2b_stall valid=%0b data=%h required 1/%h", bus.out_valid, bus.out_data, grb(rgb[0]));
        end
        cap_data.delete();
        cap_latch.delete();
        bus.out_ready = 1'b1;
        drain(40);
        n_checks++;
        if (cap_data.size() != 5) begin
            n_fail++;
            $display("FAIL b2b_count got=%0d required=5", cap_data.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (cap_data[i] !== grb(rgb[i])) begin
                    n_fail++;
                    $display("FAIL b2b_order%0d got=%h required=%h", i, cap_data[i], grb(rgb[i]));
                end
            end
        end
    endtask

    task automatic test_flush();
        int n    = 0;
        int late = 0;
        do_reset();
        brightness    = 8'd255;
        bus.out_ready = 1'b1;
        write_cmd(24'hA0B0C0, 8'd10, 1'b1);
        write_cmd(24'h010203, 8'd0, 1'b0);
        for (int c = 0; c < 20 && n < 3; c++) begin
            if (bus.out_valid && bus.out_ready) begin
                n++;
                if (n == 3)
                    flush = 1'b1;
            end
            tick();
        end
        flush = 1'b0;
        n_checks++;
        if (n != 3 || bus.out_valid !== 1'b0 || fifo_level !== 3'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_state xfers=%0d valid=%0b level=%0d busy=%0b required 3/0/0/0",
                     n, bus.out_valid, fifo_level, busy);
        end
        for (int c = 0; c < 6; c++) begin
            if (bus.out_valid && bus.out_ready)
                late++;
            tick();
        end
        n_checks++;
        if (late != 0) begin
            n_fail++;
            $display("FAIL flush_quiet late_xfers=%0d required=0", late);
        end
    endtask

    task automatic test_reset_midsend();
        do_reset();
        brightness    = 8'd255;
        bus.out_ready = 1'b0;
        write_cmd(24'h445566, 8'd5, 1'b1);
        write_cmd(24'h778899, 8'd0, 1'b0);
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b1 || fifo_level !== 3'd1) begin
            n_fail++;
            $display("FAIL midsend_pre valid=%0b level=%0d required 1/1", bus.out_valid, fifo_level);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({bus.wr_ready, bus.out_valid, bus.out_data, bus.out_latch, busy, fifo_level} !==
            {1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL midsend_reset wr_ready=%0b valid=%0b data=%h latch=%0b busy=%0b level=%0d",
                     bus.wr_ready, bus.out_valid, bus.out_data, bus.out_latch, busy, fifo_level);
        end
    endtask

    task automatic test_rgb_order();
        do_reset();
        brightness     = 8'd255;
        bus2.out_ready = 1'b0;
        bus2.wr_rgb    = 24'h112233;
        bus2.wr_repeat = 8'd0;
        bus2.wr_latch  = 1'b1;
        bus2.wr_valid  = 1'b1;
        tick();
        bus2.wr_valid  = 1'b0;
        tick();
        n_checks++;
        if (bus2.out_valid !== 1'b1 || bus2.out_data !== 24'h112233 || bus2.out_latch !== 1'b1) begin
            n_fail++;
            $display("FAIL rgb_passthru valid=%0b data=%h latch=%0b required 1/112233/1",
                     bus2.out_valid, bus2.out_data, bus2.out_latch);
        end
    endtask

    initial begin
        reset          = 1'b1;
        brightness     = 8'd255;
        flush          = 1'b0;
        bus.wr_valid   = 1'b0;
        bus.wr_rgb     = '0;
        bus.wr_repeat  = '0;
        bus.wr_latch   = 1'b0;
        bus.out_ready  = 1'b0;
        bus2.wr_valid  = 1'b0;
        bus2.wr_rgb    = '0;
        bus2.wr_repeat = '0;
        bus2.wr_latch  = 1'b0;
        bus2.out_ready = 1'b0;

        test_reset();
        test_single();
        test_repeat();
        test_brightness();
        test_back_to_back();
        test_flush();
        test_reset_midsend();
        test_rgb_order();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
